uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Parametrised UART transmit front end: serializer, configurable baud divider, FIFO for
//  general (command/status) bytes, and a valid/ready stream channel for ADC data.
//  Sits between the command logic / ADC FIFO and the SDO pin. Source switches only at
//  frame boundaries, never mid-byte.
// PARAMETERS
//  BAUD_DIV    868  clocks per UART bit (100 MHz / 115200); legal range >= 2
//  DATA_W      8    bits per character, sent LSB first
//  FIFO_DEPTH  32   general-data FIFO entries; power of 2; localparam AW = log2(FIFO_DEPTH)
//  STOP_BITS   1    stop bits per frame, 1 or 2
// PORTS
//  Clock         in   1       system clock
//  Reset         in   1       synchronous, active-high
//  generalData   in   DATA_W  byte to queue
//  generalWrite  in   1       one-cycle strobe: push generalData
//  generalFull   out  1       FIFO full
//  generalCount  out  AW+1    FIFO occupancy, 0..FIFO_DEPTH
//  overflow      out  1       sticky: a write arrived while full
//  streamMode    in   1       1 = stream channel owns the link; FIFO is held
//  streamData    in   DATA_W  stream byte
//  streamValid   in   1       streamData valid
//  streamReady   out  1       serializer takes streamData this cycle
//  SDO           out  1       serial line, idle high
//  TxBusy        out  1       frame in progress
// BEHAVIOUR
//  Reset values: SDO=1, TxBusy=0, streamReady=0, generalFull=0, generalCount=0, overflow=0.
//  Reset mid-frame aborts it: SDO=1 from the next edge; FIFO flushed; FSM returns to IDLE.
//  FSM: IDLE -> START -> DATA (DATA_W bits) -> [PARITY] -> STOP (STOP_BITS bits) -> IDLE.
//  Every bit lasts exactly BAUD_DIV clocks. The baud counter is 0..BAUD_DIV-1 and restarts on load.
//  IDLE (one cycle minimum between frames): streamMode is sampled here.
//   streamMode=1: streamReady = 1 (combinational, IDLE only). On streamValid&&streamReady,
//    load the shift register and go to START.
//   streamMode=0: if FIFO not empty, pop the head and load in the same cycle; streamReady=0.
//  SDO goes low on the edge after the load. Frame = (1+DATA_W+STOP_BITS)*BAUD_DIV clocks.
//  Back-to-back period is frame + 1 clock.
//  TxBusy=1 from the load edge to the end of the last stop bit.
//  A streamMode change mid-frame takes effect only at the next IDLE.
//  FIFO contents are retained while streaming.
//  FIFO: pointers are AW+1 bits with the wrap bit; full/empty come from pointer compare.
//   generalFull = (count == FIFO_DEPTH).
//   A write is accepted iff not full at the start of the cycle.
//   A write while full is dropped, even with a same-cycle pop, and sets overflow.
//   Simultaneous write+pop with 0 < count < DEPTH: count is unchanged.
//   Write into an empty FIFO: the byte is eligible for pop on the next cycle (no bypass).
//  overflow clears only on Reset.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: an even-parity bit (XOR of data bits) follows DATA.
//   Frame grows by one bit (BAUD_DIV clocks).
//  Not defined: no PARITY state; the frame is start + data + stop only.
// TESTING  (BAUD_DIV=4, DATA_W=8, FIFO_DEPTH=32, STOP_BITS=1 unless noted)
//  1. Reset, write 0x55 -> SDO: start 0, then 1,0,1,0,1,0,1,0, stop 1, each bit 4 clk.
//     TxBusy high for 40 clk.
//  2. 34 consecutive writes from idle -> first byte is popped; 33rd leaves count=32, full=1.
//     34th is dropped, overflow=1. All 33 bytes leave SDO in order, 41 clk apart.
//  3. streamMode=1, streamValid held, data 0xA5 -> streamReady pulses 1 clk every 41 clk.
//     SDO repeats 0xA5 frames.
//  4. General frame in flight, raise streamMode mid-bit 3 -> frame completes intact.
//     Next frame comes from the stream; queued FIFO bytes resume after streamMode drops.
//  5. Assert Reset during data bit 3 with count=5 -> next edge: SDO=1, TxBusy=0,
//     generalCount=0, overflow=0.
//  6. UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 precedes stop.
//     Frame is 44 clk, TxBusy high for 44 clk.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: UART transmit front end. A general-data FIFO and a
// valid/ready stream channel share one serializer; the source is chosen only
// in IDLE, so a frame is never split between sources.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit
// after the data bits.
module uart_tx_arbiter #(
  parameter int BAUD_DIV   = 868,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int STOP_BITS  = 1
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [DATA_W-1:0]               generalData,
  input  logic                            generalWrite,
  output logic                            generalFull,
  output logic [$clog2(FIFO_DEPTH):0]     generalCount,
  output logic                            overflow,
  input  logic                            streamMode,
  input  logic [DATA_W-1:0]               streamData,
  input  logic                            streamValid,
  output logic                            streamReady,
  output logic                            SDO,
  output logic                            TxBusy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_W + 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;
`endif

  txState_t state, stateNext;

  // FIFO storage and pointers (AW+1 bits, MSB is the wrap bit)
  logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
  logic [AW:0]       wrPtr, rdPtr;
  logic              fifoEmpty, fifoFull, wrAccept, popFifo;
  logic [DATA_W-1:0] headData;

  // Serializer datapath
  logic [BW-1:0]     baudCnt;
  logic [CW-1:0]     bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic              parityBit;
  logic              bitDone, lastData, lastStop;
  logic              streamTake, loadFrame;
  logic [DATA_W-1:0] loadData;

  assign fifoEmpty    = (wrPtr == rdPtr);
  assign fifoFull     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign generalFull  = fifoFull;
  assign generalCount = wrPtr - rdPtr;
  assign headData     = fifoMem[rdPtr[AW-1:0]];

  // Fullness is judged before this cycle's pop, so a write while full is dropped
  assign wrAccept    = generalWrite && !fifoFull;
  assign popFifo     = (state == IDLE) && !streamMode && !fifoEmpty;
  assign streamReady = (state == IDLE) && streamMode;
  assign streamTake  = streamReady && streamValid;
  assign loadFrame   = popFifo || streamTake;
  assign loadData    = streamMode ? streamData : headData;

  assign bitDone  = (baudCnt == BW'(BAUD_DIV - 1));
  assign lastData = (bitCnt == CW'(DATA_W - 1));
  assign lastStop = (bitCnt == CW'(STOP_BITS - 1));

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrAccept)
        wrPtr <= wrPtr + 1'b1;
      if (popFifo)
        rdPtr <= rdPtr + 1'b1;
      if (generalWrite && fifoFull)
        overflow <= 1'b1;
    end
  end

  // FIFO storage write (contents need no reset; pointers define validity)
  always_ff @(posedge Clock) begin
    if (wrAccept)
      fifoMem[wrPtr[AW-1:0]] <= generalData;
  end

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (loadFrame) stateNext = START;
      START: if (bitDone) stateNext = DATA;
      DATA: begin
        if (bitDone && lastData) begin
`ifdef UART_TX_PARITY_EN
          stateNext = PARITY;
`else
          stateNext = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bitDone) stateNext = STOP;
`endif
      STOP:  if (bitDone && lastStop) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Serializer: SDO is registered and updated on the edge that enters each bit,
  // so the line changes on the same edge as the state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SDO       <= 1'b1;
      TxBusy    <= 1'b0;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
    end else begin
      TxBusy <= (stateNext != IDLE);
      if (state == IDLE) begin
        baudCnt <= '0;
        bitCnt  <= '0;
        SDO     <= 1'b1;
        if (loadFrame) begin
          shiftReg  <= loadData;
          parityBit <= ^loadData;
          SDO       <= 1'b0;
        end
      end else begin
        baudCnt <= bitDone ? '0 : baudCnt + 1'b1;
        if (bitDone) begin
          case (stateNext)
            DATA: begin
              SDO      <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitCnt   <= (state == DATA) ? bitCnt + 1'b1 : '0;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: SDO <= parityBit;
`endif
            STOP: begin
              SDO    <= 1'b1;
              bitCnt <= (state == STOP) ? bitCnt + 1'b1 : '0;
            end
            default: SDO <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (BAUD_DIV=4).
// Bytes are queued as stimulus is accepted; a line monitor decodes SDO frames
// and compares each against the queue head.
module tb_uart_tx_arbiter;

  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB     = 1 + 8 + PB + 1;
  localparam int FRAME  = NB * BAUD;
  localparam int PERIOD = FRAME + 1;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] generalData;
  logic       generalWrite;
  logic       generalFull;
  logic [5:0] generalCount;
  logic       overflow;
  logic       streamMode;
  logic [7:0] streamData;
  logic       streamValid;
  logic       streamReady;
  logic       SDO;
  logic       TxBusy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  logic [7:0]  sbQ[$];
  bit          monEnable = 1'b1;
  bit          gapCheck  = 1'b0;

  uart_tx_arbiter #(
    .BAUD_DIV  (BAUD),
    .DATA_W    (8),
    .FIFO_DEPTH(32),
    .STOP_BITS (1)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .generalData (generalData),
    .generalWrite(generalWrite),
    .generalFull (generalFull),
    .generalCount(generalCount),
    .overflow    (overflow),
    .streamMode  (streamMode),
    .streamData  (streamData),
    .streamValid (streamValid),
    .streamReady (streamReady),
    .SDO         (SDO),
    .TxBusy      (TxBusy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor: decode each frame mid-bit and compare with the scoreboard
  always begin : monitor
    logic [15:0] fr;
    int unsigned fStart, prevStart;
    bit          monOn;
    @(negedge Clock);
    if (SDO === 1'b0 && !Reset) begin
      fStart = cyc;
      monOn  = monEnable;
      if (monOn && gapCheck)
        checkVal("framePeriod", fStart - prevStart, PERIOD);
      prevStart = fStart;
      fr = '0;
      repeat (2) @(negedge Clock);
      fr[0] = SDO;
      for (int b = 1; b < NB; b++) begin
        repeat (BAUD) @(negedge Clock);
        fr[b] = SDO;
      end
      @(negedge Clock);
      if (monOn) begin
        checkVal("startBit", fr[0], 1'b0);
        checkVal("stopBit", fr[NB-1], 1'b1);
        if (PB == 1)
          checkVal("parityBit", fr[9], ^fr[8:1]);
        checkVal("sbHasEntry", sbQ.size() > 0, 1'b1);
        if (sbQ.size() > 0)
          checkVal("frameData", fr[8:1], sbQ.pop_front());
      end
    end
  end

  task automatic writeByte(input logic [7:0] d, input bit expectOut);
    @(negedge Clock);
    generalData  = d;
    generalWrite = 1'b1;
    if (expectOut) sbQ.push_back(d);
    @(negedge Clock);
    generalWrite = 1'b0;
  endtask

  task automatic waitBusy(input string tag);
    int n = 0;
    while (!TxBusy && n < 200) begin
      @(negedge Clock);
      n++;
    end
    checkVal(tag, TxBusy, 1'b1);
  endtask

  task automatic measureBusy();
    int n = 0;
    waitBusy("busyRise");
    checkVal("sdoLowAtLoad", SDO, 1'b0);
    while (TxBusy && n < 200) begin
      @(negedge Clock);
      n++;
    end
    checkVal("busyLen", n, FRAME);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (sbQ.size() == 0 && !TxBusy) break;
    end
    checkVal("drain", sbQ.size(), 0);
    repeat (3) @(negedge Clock);
  endtask

  initial begin : stimulus
    int pulses;
    int unsigned lastPulse;
    Reset        = 1'b1;
    generalData  = '0;
    generalWrite = 1'b0;
    streamMode   = 1'b0;
    streamData   = '0;
    streamValid  = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // Reset state
    checkVal("rstSDO", SDO, 1'b1);
    checkVal("rstTxBusy", TxBusy, 1'b0);
    checkVal("rstStreamReady", streamReady, 1'b0);
    checkVal("rstFull", generalFull, 1'b0);
    checkVal("rstCount", generalCount, 0);
    checkVal("rstOverflow", overflow, 1'b0);

    // Single bytes, frame length
    writeByte(8'h55, 1'b1);
    checkVal("countAfterWrite", generalCount, 1);
    measureBusy();
    waitDrain(200);
    writeByte(8'h07, 1'b1);
    measureBusy();
    waitDrain(200);

    // Burst of 34 writes: one popped at once, 33rd fills, 34th overflows
    for (int k = 0; k < 34; k++) begin
      @(negedge Clock);
      if (k == 33) begin
        checkVal("burstCount33", generalCount, 32);
        checkVal("burstFull33", generalFull, 1'b1);
        checkVal("burstOvf33", overflow, 1'b0);
      end
      generalData  = 8'(k * 7 + 3);
      generalWrite = 1'b1;
      if (k < 33) sbQ.push_back(8'(k * 7 + 3));
    end
    @(negedge Clock);
    generalWrite = 1'b0;
    checkVal("burstCount34", generalCount, 32);
    checkVal("burstFull34", generalFull, 1'b1);
    checkVal("burstOvf34", overflow, 1'b1);
    gapCheck = 1'b1;
    waitDrain(33 * PERIOD + 100);
    gapCheck = 1'b0;
    checkVal("burstEmpty", generalCount, 0);
    checkVal("burstFullClr", generalFull, 1'b0);

    // Stream channel: ready only in IDLE, one pulse per frame period
    streamMode = 1'b1;
    @(negedge Clock);
    checkVal("streamReadyIdle", streamReady, 1'b1);
    checkVal("streamNoLoad", TxBusy, 1'b0);
    streamData  = 8'hA5;
    streamValid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      if (streamReady) begin
        if (pulses > 0) checkVal("readyGap", cyc - lastPulse, PERIOD);
        lastPulse = cyc;
        sbQ.push_back(8'hA5);
        pulses++;
      end
      if (pulses == 3) break;
      @(negedge Clock);
    end
    checkVal("streamPulses", pulses, 3);
    @(negedge Clock);
    streamValid = 1'b0;
    streamMode  = 1'b0;
    waitDrain(300);
    checkVal("ovfSticky", overflow, 1'b1);

    // streamMode raised mid-frame: general frame completes, then stream, then FIFO resumes
    writeByte(8'hC3, 1'b1);
    waitBusy("t4Busy");
    repeat (18) @(negedge Clock);
    streamMode  = 1'b1;
    streamValid = 1'b1;
    streamData  = 8'h3C;
    @(negedge Clock);
    checkVal("readyMidFrame", streamReady, 1'b0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (streamReady) begin
        pulses = 1;
        sbQ.push_back(8'h3C);
        break;
      end
      @(negedge Clock);
    end
    checkVal("t4StreamTaken", pulses, 1);
    @(negedge Clock);
    streamValid = 1'b0;
    writeByte(8'h12, 1'b1);
    writeByte(8'h34, 1'b1);
    checkVal("t4Held", generalCount, 2);
    for (int i = 0; i < 100 && TxBusy; i++) @(negedge Clock);
    repeat (10) @(negedge Clock);
    checkVal("t4HeldIdle", generalCount, 2);
    checkVal("t4NoPop", TxBusy, 1'b0);
    streamMode = 1'b0;
    waitDrain(3 * PERIOD + 50);

    // Reset during data bit 3 with five bytes queued
    monEnable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      generalData  = 8'(8'hE0 + k);
      generalWrite = 1'b1;
    end
    @(negedge Clock);
    generalWrite = 1'b0;
    checkVal("t5Count", generalCount, 5);
    repeat (14) @(negedge Clock);
    checkVal("t5Busy", TxBusy, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checkVal("t5SDO", SDO, 1'b1);
    checkVal("t5TxBusy", TxBusy, 1'b0);
    checkVal("t5Count0", generalCount, 0);
    checkVal("t5Ovf", overflow, 1'b0);
    checkVal("t5Full", generalFull, 1'b0);
    repeat (50) @(negedge Clock);
    checkVal("t5StaysIdle", TxBusy, 1'b0);
    checkVal("t5LineIdle", SDO, 1'b1);
    monEnable = 1'b1;
    writeByte(8'h81, 1'b1);
    measureBusy();
    waitDrain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
